// File: rtl/pitch_pkg.sv
// Shared types and defaults for the pitch analyser window feeder.
package pitch_pkg;

    localparam int DEF_DATA_WIDTH       = 8;
    localparam int DEF_WINDOW_SIZE_BITS = 8;
    localparam int DEF_MAX_TAU          = 40;
    localparam int TAU_WIDTH            = 8;

    typedef enum logic [1:0] {
        FILL,
        ARM,
        RUN,
        DONE
    } feeder_state_e;

    function automatic int window_len(input int wsb, input int max_tau);
        return (1 << wsb) + max_tau;
    endfunction

endpackage

// File: rtl/pitch_window_feeder_if.sv
// Serial sample stream (valid/ready) feeding the pitch window.
interface pitch_window_feeder_if #(
    parameter int DW = 8
);

    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/window_shift_reg.sv
// N-slot sample shift register; slot 0 oldest, new samples enter the top slot.
module window_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int SLOTS      = 296
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic [SLOTS*DATA_WIDTH-1:0] win_o
);

    logic [SLOTS*DATA_WIDTH-1:0] win_q;
    logic [SLOTS*DATA_WIDTH-1:0] win_d;

    assign win_d = {data_i, win_q[SLOTS*DATA_WIDTH-1:DATA_WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_q <= '0;
        end else if (load_i) begin
            win_q <= win_d;
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/pitch_window_feeder.sv
// Sliding-window producer for the pitch analyser; holds it in reset while filling.
// Optional watchdog on the analysis phase: PITCH_WINDOW_FEEDER_TIMEOUT_EN.
module pitch_window_feeder
    import pitch_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int WINDOW_SIZE_BITS = DEF_WINDOW_SIZE_BITS,
    parameter int MAX_TAU          = DEF_MAX_TAU,
    parameter int HOP              = 128
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = 1 << 20
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pitch_window_feeder_if.slave smp,
    output logic [window_len(WINDOW_SIZE_BITS, MAX_TAU)*DATA_WIDTH-1:0] win_data,
    output logic                 ana_reset,
    input  logic                 ana_ready,
    input  logic [TAU_WIDTH-1:0] ana_min_tau,
    output logic                 tau_valid,
    output logic [TAU_WIDTH-1:0] tau_out
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
    ,
    output logic                 tau_timeout
`endif
);

    localparam int N     = window_len(WINDOW_SIZE_BITS, MAX_TAU);
    localparam int CNT_W = $clog2(N + 1);

    feeder_state_e        state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [CNT_W-1:0]     need_q;
    logic                 s_ready_q;
    logic                 ana_reset_q;
    logic                 tau_valid_q;
    logic [TAU_WIDTH-1:0] tau_out_q;
    logic                 accept;

`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            tau_timeout_q;
    logic            wd_expired;

    assign wd_expired  = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign tau_timeout = tau_timeout_q;
`endif

    assign accept = smp.s_valid && s_ready_q;
    assign cnt_d  = cnt_q + CNT_W'(1);

    window_shift_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .SLOTS     (N)
    ) u_win (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (accept),
        .data_i (smp.s_data),
        .win_o  (win_data)
    );

    // Outputs are registered alongside the state so each
    // state's handshake values appear in the cycle it is entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            need_q      <= CNT_W'(N);
            s_ready_q   <= 1'b0;
            ana_reset_q <= 1'b1;
            tau_valid_q <= 1'b0;
            tau_out_q   <= '0;
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
            wd_q          <= '0;
            tau_timeout_q <= 1'b0;
`endif
        end else begin
            tau_valid_q <= 1'b0;
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
            tau_timeout_q <= 1'b0;
`endif
            unique case (state_q)
                FILL: begin
                    s_ready_q   <= 1'b1;
                    ana_reset_q <= 1'b1;
                    if (accept) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == need_q) begin
                            state_q     <= ARM;
                            s_ready_q   <= 1'b0;
                            ana_reset_q <= 1'b0;
                        end
                    end
                end
                ARM: begin
                    state_q <= RUN;
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
                    wd_q <= '0;
`endif
                end
                RUN: begin
                    if (ana_ready) begin
                        state_q     <= DONE;
                        tau_out_q   <= ana_min_tau;
                        tau_valid_q <= 1'b1;
                        ana_reset_q <= 1'b1;
                    end
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
                    else if (wd_expired) begin
                        state_q       <= DONE;
                        tau_out_q     <= '0;
                        tau_valid_q   <= 1'b1;
                        tau_timeout_q <= 1'b1;
                        ana_reset_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
                DONE: begin
                    state_q   <= FILL;
                    cnt_q     <= '0;
                    need_q    <= CNT_W'(HOP);
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign smp.s_ready = s_ready_q;
    assign ana_reset   = ana_reset_q;
    assign tau_valid   = tau_valid_q;
    assign tau_out     = tau_out_q;

endmodule

// File: tb/tb_pitch_window_feeder.sv
// Directed bench for pitch_window_feeder with N=20, HOP=8 and a bench-driven analyser.
module tb_pitch_window_feeder;

    localparam int DW  = 8;
    localparam int WSB = 4;
    localparam int MT  = 4;
    localparam int NN  = (1 << WSB) + MT;
    localparam int HOP = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             ana_ready = 1'b0;
    logic [7:0]       ana_min_tau = '0;
    logic [NN*DW-1:0] win_data;
    logic             ana_reset;
    logic             tau_valid;
    logic [7:0]       tau_out;
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
    logic             tau_timeout;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] model[$];

    pitch_window_feeder_if #(.DW(DW)) sif();

    pitch_window_feeder #(
        .DATA_WIDTH      (DW),
        .WINDOW_SIZE_BITS(WSB),
        .MAX_TAU         (MT),
        .HOP             (HOP)
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES  (16)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .smp        (sif),
        .win_data   (win_data),
        .ana_reset  (ana_reset),
        .ana_ready  (ana_ready),
        .ana_min_tau(ana_min_tau),
        .tau_valid  (tau_valid),
        .tau_out    (tau_out)
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
        ,
        .tau_timeout(tau_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       ar;
        logic [7:0] mt;
        logic       e_rdy;
        logic       e_ars;
        logic       e_tv;
        logic [7:0] e_to;
    } vec_t;

    vec_t tab[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NN*DW-1:0] exp_win();
        logic [NN*DW-1:0] w;
        int off;
        w = '0;
        off = NN - model.size();
        for (int i = 0; i < NN; i++)
            if (i >= off) w[i*DW +: DW] = model[i-off];
        return w;
    endfunction

    task automatic chk_win(input string nm);
        logic [NN*DW-1:0] e;
        e = exp_win();
        checks++;
        if (win_data !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, win_data, e);
        end
    endtask

    function automatic logic [7:0] slot(input int i);
        return win_data[i*DW +: DW];
    endfunction

    task automatic send(input logic [7:0] d);
        int w;
        w = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        while (!sif.s_ready && w < 50) begin
            tick();
            w++;
        end
        if (!sif.s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got s_ready=0 want 1 data %0d", d);
        end else begin
            tick();
            model.push_back(d);
            if (model.size() > NN) void'(model.pop_front());
        end
        sif.s_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    initial begin
        int n;
        int tv_seen;
        int ar_low;
        logic acc;

        // ARM -> RUN -> RUN -> DONE -> FILL, ana_ready in ARM is ignored
        tab[0] = '{1'b1, 8'd99, 1'b1, 8'd55, 1'b0, 1'b0, 1'b0, 8'd0};
        tab[1] = '{1'b1, 8'd99, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0};
        tab[2] = '{1'b1, 8'd99, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0};
        tab[3] = '{1'b1, 8'd99, 1'b1, 8'd9,  1'b0, 1'b1, 1'b1, 8'd9};
        tab[4] = '{1'b0, 8'd0,  1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd9};

        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        repeat (2) tick();
        chk("rst_s_ready", sif.s_ready, 1'b0);
        chk("rst_ana_reset", ana_reset, 1'b1);
        chk("rst_tau_valid", tau_valid, 1'b0);
        chk("rst_tau_out", tau_out, 8'd0);
        chk_win("rst_win");

        reset_n = 1'b1;
        chk("rel_s_ready_0", sif.s_ready, 1'b0);
        tick();
        chk("rel_s_ready_1", sif.s_ready, 1'b1);

        for (int i = 1; i <= NN; i++) begin
            chk("fill1_rdy", sif.s_ready, 1'b1);
            send(8'(i));
            if (i < NN) chk("fill1_ars", ana_reset, 1'b1);
        end
        chk("fill1_ars_fall", ana_reset, 1'b0);
        chk("fill1_rdy_low", sif.s_ready, 1'b0);
        chk("fill1_slot0", slot(0), 8'd1);
        chk("fill1_slot19", slot(NN-1), 8'd20);
        chk_win("fill1_win");

        for (int i = 0; i < 5; i++) begin
            sif.s_valid = tab[i].sv;
            sif.s_data  = tab[i].sd;
            ana_ready   = tab[i].ar;
            ana_min_tau = tab[i].mt;
            tick();
            chk($sformatf("tab%0d_rdy", i), sif.s_ready, tab[i].e_rdy);
            chk($sformatf("tab%0d_ars", i), ana_reset, tab[i].e_ars);
            chk($sformatf("tab%0d_tv", i), tau_valid, tab[i].e_tv);
            chk($sformatf("tab%0d_to", i), tau_out, tab[i].e_to);
        end
        ana_ready = 1'b0;
        sif.s_valid = 1'b0;
        chk_win("frozen_win");

        for (int i = 21; i <= 27; i++) send(8'(i));
        chk("hop7_ars", ana_reset, 1'b1);
        chk("hop7_rdy", sif.s_ready, 1'b1);
        send(8'd28);
        chk("hop8_ars", ana_reset, 1'b0);
        chk("win2_slot0", slot(0), 8'd9);
        chk("win2_slot19", slot(NN-1), 8'd28);
        chk_win("win2");

        tick();
        ana_ready = 1'b1;
        ana_min_tau = 8'd17;
        tick();
        chk("cap2_tv", tau_valid, 1'b1);
        chk("cap2_to", tau_out, 8'd17);
        ana_ready = 1'b0;
        tick();
        chk("cap2_rdy", sif.s_ready, 1'b1);
        chk("cap2_tv_low", tau_valid, 1'b0);

        tv_seen = 0;
        ar_low  = 0;
        for (int k = 0; k < 14; k++) begin
            sif.s_valid = (k % 2 == 0);
            sif.s_data  = 8'(29 + k / 2);
            ana_ready   = (k == 3 || k == 8);
            ana_min_tau = 8'd77;
            acc = sif.s_valid && sif.s_ready;
            tick();
            if (acc) begin
                model.push_back(sif.s_data);
                if (model.size() > NN) void'(model.pop_front());
            end
            if (tau_valid) tv_seen++;
            if (!ana_reset) ar_low++;
        end
        ana_ready = 1'b0;
        sif.s_valid = 1'b0;
        chk("thr_no_tv", tv_seen, 0);
        chk("thr_ars_held", ar_low, 0);
        chk("thr_tau_kept", tau_out, 8'd17);
        send(8'd36);
        chk("thr_ars_fall", ana_reset, 1'b0);
        chk("thr_slot0", slot(0), 8'd17);
        chk("thr_slot19", slot(NN-1), 8'd36);

        tick();
        #2;
        reset_n = 1'b0;
        #1;
        model.delete();
        chk("mid_rst_rdy", sif.s_ready, 1'b0);
        chk("mid_rst_ars", ana_reset, 1'b1);
        chk("mid_rst_tv", tau_valid, 1'b0);
        chk("mid_rst_to", tau_out, 8'd0);
        chk_win("mid_rst_win");
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < NN - 1; i++) send(8'(100 + i));
        chk("refill19_ars", ana_reset, 1'b1);
        send(8'(100 + NN - 1));
        chk("refill20_ars", ana_reset, 1'b0);
        chk_win("refill_win");
        tick();
        ana_ready = 1'b1;
        ana_min_tau = 8'd33;
        tick();
        chk("cap3_tv", tau_valid, 1'b1);
        chk("cap3_to", tau_out, 8'd33);
`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
        chk("cap3_tmo", tau_timeout, 1'b0);
`endif
        ana_ready = 1'b0;
        tick();

`ifdef PITCH_WINDOW_FEEDER_TIMEOUT_EN
        for (int i = 0; i < HOP; i++) send(8'(150 + i));
        chk("tmo_ars_fall", ana_reset, 1'b0);
        tick();
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (tau_valid) break;
        end
        chk("tmo_cycles", n, 16);
        chk("tmo_tv", tau_valid, 1'b1);
        chk("tmo_to", tau_out, 8'd0);
        chk("tmo_flag", tau_timeout, 1'b1);
        tick();
        chk("tmo_flag_low", tau_timeout, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
